// File: rtl/mixed_mem_read_responder.sv
// Read-side responder for the BSIZE-wordline memory: credit-limited request intake,
// one-cycle synchronous memory read, and an in-order buffered response channel.
package mixedInclude_package;
    parameter int BSIZE      = 10;
    parameter int BSIZE_LOG2 = 4;
endpackage

module mixed_mem_read_responder
    import mixedInclude_package::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [BSIZE_LOG2-1:0] req_addr,
    output logic                  mem_rd_en,
    output logic [BSIZE_LOG2-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0]     mem_rd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic [7:0]            err_cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]      cnt;
    logic [BSIZE_LOG2-1:0] last_addr;
    logic                  s1_valid;
    logic                  s1_err;

    logic [DATA_W-1:0]     fifo_data [DEPTH];
    logic                  fifo_err  [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occ;

    logic                  accept;
    logic                  in_range;
    logic                  pop;
    logic                  push;
    logic [DATA_W-1:0]     push_data;
    logic [CNT_W-1:0]      occ_after_pop;
    logic [CNT_W-1:0]      occ_next;
    logic [PTR_W-1:0]      rd_ptr_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits come only from registered cnt, so rsp_ready never reaches req_ready.
    assign req_ready     = rst_n & (cnt < CNT_W'(DEPTH));
    assign accept        = req_valid & req_ready;
    assign in_range      = req_addr < BSIZE_LOG2'(BSIZE);
    assign mem_rd_en     = accept & in_range;
    assign mem_rd_addr   = mem_rd_en ? req_addr : last_addr;

    assign pop           = rsp_valid & rsp_ready;
    assign push          = s1_valid;
    assign push_data     = s1_err ? '0 : mem_rd_data;
    assign occ_after_pop = occ - CNT_W'(pop);
    assign occ_next      = occ_after_pop + CNT_W'(push);
    assign rd_ptr_next   = pop ? ptr_inc(rd_ptr) : rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            last_addr <= '0;
            s1_valid  <= 1'b0;
            s1_err    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (accept && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!accept && pop) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (mem_rd_en) begin
                last_addr <= req_addr;
            end
            s1_valid <= accept;
            s1_err   <= accept & ~in_range;
            if (pop && rsp_err && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_err[wr_ptr]  <= s1_err;
        end
    end

    // The output registers mirror the head entry; an empty buffer forwards the push directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr    <= rd_ptr_next;
            occ       <= occ_next;
            rsp_valid <= (occ_next != '0);
            if (occ_after_pop != '0) begin
                rsp_data <= fifo_data[rd_ptr_next];
                rsp_err  <= fifo_err[rd_ptr_next];
            end else if (push) begin
                rsp_data <= push_data;
                rsp_err  <= s1_err;
            end
        end
    end
endmodule

// File: doc/mixed_mem_read_responder.md
Name: mixed_mem_read_responder

Overview:
- Read-side responder for the BSIZE-wordline memory defined in mixedInclude_package (BSIZE = 10, BSIZE_LOG2 = 4).
- Accepts read requests on a valid/ready channel and reads the memory's synchronous read port.
- Returns data plus an error flag on a buffered valid/ready response channel, in order, with backpressure.
- Counterpart to the existing write-side initiator that fills the memory.

Parameters:
- DATA_W, 32, memory word width.
- DEPTH, 4, response buffer entries; also the maximum outstanding requests (minimum 3).
- Address width is BSIZE_LOG2 and the valid range is 0..BSIZE-1, both imported from mixedInclude_package.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_addr  in  BSIZE_LOG2  wordline address.
- mem_rd_en  out  1  memory read enable.
- mem_rd_addr  out  BSIZE_LOG2  memory read address.
- mem_rd_data  in  DATA_W  memory read data, valid the cycle after mem_rd_en.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_data  out  DATA_W  read data; 0 on error.
- rsp_err  out  1  address was >= BSIZE.
- err_cnt  out  8  saturating count of error responses.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: req_ready 0 while in reset, then 1; mem_rd_en 0; mem_rd_addr 0; rsp_valid 0; rsp_data 0; rsp_err 0; err_cnt 0.
- Reset mid-operation discards all in-flight and buffered responses; nothing is replayed.
- Credit counter cnt (0..DEPTH) tracks outstanding requests.
  - +1 on request accept (req_valid & req_ready).
  - -1 on response handshake (rsp_valid & rsp_ready).
  - Unchanged when both happen in the same cycle.
- req_ready = (cnt < DEPTH), from registered state only; no combinational path from rsp_ready.
- At cnt == DEPTH with a pop in the same cycle, req_ready stays 0 that cycle and rises the next.
- Accept cycle T, in-range (req_addr < BSIZE):
  - mem_rd_en = 1 and mem_rd_addr = req_addr combinationally in T.
  - Stage-1 register captures {valid=1, err=0}.
- Accept cycle T, out-of-range (req_addr 10..15):
  - mem_rd_en = 0 and mem_rd_addr holds its last value.
  - Stage-1 captures {valid=1, err=1}.
- Cycle T+1: if stage-1 is valid, push {err ? 0 : mem_rd_data, err} into the FIFO at the end of T+1.
- Cycle T+2: entry is at the FIFO head, so rsp_valid = 1. Minimum request-to-response latency is 2 cycles.
- FIFO: DEPTH entries, circular pointers wrap at DEPTH-1 -> 0, first-word registered output.
  - Overflow cannot occur because cnt bounds occupancy (stage-1 plus FIFO <= DEPTH).
- Response-channel rules:
  - rsp_valid stays high and rsp_data/rsp_err stay stable until rsp_ready.
  - Responses are in request order.
  - A push and a pop in the same cycle are both honoured.
- Throughput: with rsp_ready held at 1 and DEPTH >= 3, one request is accepted every cycle.
- err_cnt: +1 on each error-response handshake; saturates at 255.
- Request-channel stability: req_addr must be stable while req_valid is high and req_ready is low (checked by bench assertion).

Test Plan:
- Preload mem[3] = 0xDEAD_BEEF; request addr 3 with rsp_ready = 1 -> mem_rd_en pulses in the accept cycle, and rsp_valid appears 2 cycles later with rsp_data 0xDEADBEEF, rsp_err 0.
- Request addr 12, then addr 10 -> no mem_rd_en for either; two responses with rsp_err 1, rsp_data 0; err_cnt goes 0 -> 2.
- Hold rsp_ready = 0 and issue 6 back-to-back requests (addrs 0..5) -> exactly 4 accepted and req_ready falls.
  - Then rsp_ready = 1 -> responses mem[0..3] in order; req_ready returns the cycle after the first pop.
  - Addrs 4 and 5 complete afterwards.
- Stream 20 requests, addrs cycling 0..9, with rsp_ready = 1 -> 20 accepts in 20 consecutive cycles; responses in order, one per cycle, with pointer wrap exercised.
- Assert rst_n low with 3 responses buffered -> rsp_valid 0 immediately, cnt 0, and req_ready 1 the first cycle after release.
  - A subsequent addr 7 read returns only mem[7].
- Force 260 error responses -> err_cnt saturates at 255 and holds.
